mem_responder: RTL and testbench

- Memory-side responder for the byte-serial memory bus driven by the CPU memory controller, which issues `addr`, `mem_ctrl_wr` and write data and collects `rdata`.
- Serves a synchronous byte-wide RAM with a registered, 1-cycle read latency.
- Decodes a small I/O window carrying a TX FIFO (CPU to host) and a 1-entry RX holding register (host to CPU).
- Sits at the top level between the controller's bus pins and the RAM/host-I/O fabric.

---
 rtl/mem_responder_if.sv | 26 ++
 rtl/mem_responder.sv | 131 +++++++++++++
 tb/tb_mem_responder.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/mem_responder_if.sv
// Bus and host-I/O signal bundle for mem_responder.
// master = controller/host side, slave = responder side.
interface mem_responder_if #(
    parameter int unsigned ADDR_WIDTH = 17
);
    logic                  mem_ctrl_wr;
    logic [ADDR_WIDTH-1:0] addr;
    logic [7:0]            wdata;
    logic [7:0]            rdata;
    logic [7:0]            io_tx_data;
    logic                  io_tx_valid;
    logic                  io_tx_ready;
    logic [7:0]            io_rx_data;
    logic                  io_rx_valid;
    logic                  io_rx_ready;

    modport master (
        output mem_ctrl_wr, addr, wdata, io_tx_ready, io_rx_data, io_rx_valid,
        input  rdata, io_tx_data, io_tx_valid, io_rx_ready
    );

    modport slave (
        input  mem_ctrl_wr, addr, wdata, io_tx_ready, io_rx_data, io_rx_valid,
        output rdata, io_tx_data, io_tx_valid, io_rx_ready
    );
endinterface

// File: rtl/mem_responder.sv
// Memory-side responder: byte RAM (1-cycle registered read) plus I/O window with TX FIFO and RX holding register.
module mem_responder #(
    parameter int unsigned ADDR_WIDTH = 17,
    parameter int unsigned RAM_AW     = 16,
    parameter int unsigned TX_DEPTH   = 8,
    parameter string       INIT_FILE  = "ram.data"
) (
    input  logic clk,
    input  logic rst,
    mem_responder_if.slave bus
);
    localparam int unsigned RAM_SIZE = 2 ** RAM_AW;
    localparam int unsigned PTR_W    = $clog2(TX_DEPTH);
    localparam int unsigned CNT_W    = PTR_W + 1;

    logic [7:0]       ram_q [RAM_SIZE];
    logic [7:0]       tx_mem_q [TX_DEPTH];
    logic [PTR_W-1:0] tx_rd_ptr_q, tx_rd_ptr_d;
    logic [PTR_W-1:0] tx_wr_ptr_q, tx_wr_ptr_d;
    logic [CNT_W-1:0] tx_cnt_q, tx_cnt_d;
    logic             ovf_q, ovf_d;
    logic             rx_full_q, rx_full_d;
    logic [7:0]       rx_data_q, rx_data_d;
    logic [7:0]       rdata_q, rdata_d;

    logic              io_sel;
    logic [2:0]        io_off;
    logic [RAM_AW-1:0] ram_idx;
    logic              ram_we;
    logic              tx_full;
    logic              tx_valid;
    logic              tx_push_req;
    logic              tx_push;
    logic              tx_pop;
    logic              rx_rd;
    logic              rx_cap;

    localparam string unused_init_file = INIT_FILE;

    // Upper RAM-space address bits are don't-care, so the RAM aliases across them
    if (RAM_AW < ADDR_WIDTH - 1) begin : g_alias
        logic unused_alias_bits;
        assign unused_alias_bits = ^bus.addr[ADDR_WIDTH-2:RAM_AW];
    end

    assign io_sel   = bus.addr[ADDR_WIDTH-1];
    assign io_off   = bus.addr[2:0];
    assign ram_idx  = bus.addr[RAM_AW-1:0];
    assign ram_we   = !io_sel && bus.mem_ctrl_wr;
    assign tx_full  = (tx_cnt_q == CNT_W'(TX_DEPTH));
    assign tx_valid = (tx_cnt_q != '0);
    assign tx_pop   = tx_valid && bus.io_tx_ready;

    // A push into a full FIFO is still accepted when a pop frees the head slot in the same cycle
    assign tx_push_req = io_sel && bus.mem_ctrl_wr && (io_off == 3'd0);
    assign tx_push     = tx_push_req && (!tx_full || tx_pop);
    assign rx_rd       = io_sel && !bus.mem_ctrl_wr && (io_off == 3'd0);
    assign rx_cap      = bus.io_rx_valid && !rx_full_q;

    always_comb begin
        tx_rd_ptr_d = tx_rd_ptr_q;
        tx_wr_ptr_d = tx_wr_ptr_q;
        tx_cnt_d    = tx_cnt_q;
        ovf_d       = ovf_q;
        rx_full_d   = rx_full_q;
        rx_data_d   = rx_data_q;
        rdata_d     = rdata_q;

        if (tx_push) tx_wr_ptr_d = tx_wr_ptr_q + PTR_W'(1);
        if (tx_pop)  tx_rd_ptr_d = tx_rd_ptr_q + PTR_W'(1);
        case ({tx_push, tx_pop})
            2'b10:   tx_cnt_d = tx_cnt_q + CNT_W'(1);
            2'b01:   tx_cnt_d = tx_cnt_q - CNT_W'(1);
            default: tx_cnt_d = tx_cnt_q;
        endcase

        if (tx_push_req && tx_full && !tx_pop) ovf_d = 1'b1;
        if (io_sel && bus.mem_ctrl_wr && (io_off == 3'd4)) ovf_d = 1'b0;

        // Capture only happens while empty and a destructive read only while full, so they never collide
        if (rx_cap) begin
            rx_full_d = 1'b1;
            rx_data_d = bus.io_rx_data;
        end else if (rx_rd && rx_full_q) begin
            rx_full_d = 1'b0;
        end

        if (!bus.mem_ctrl_wr) begin
            if (!io_sel) begin
                rdata_d = ram_q[ram_idx];
            end else begin
                case (io_off)
                    3'd0:    rdata_d = rx_full_q ? rx_data_q : 8'h00;
                    3'd4:    rdata_d = {5'b0, ovf_q, rx_full_q, tx_full};
                    default: rdata_d = 8'h00;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_rd_ptr_q <= '0;
            tx_wr_ptr_q <= '0;
            tx_cnt_q    <= '0;
            ovf_q       <= 1'b0;
            rx_full_q   <= 1'b0;
            rx_data_q   <= 8'h00;
            rdata_q     <= 8'h00;
        end else begin
            tx_rd_ptr_q <= tx_rd_ptr_d;
            tx_wr_ptr_q <= tx_wr_ptr_d;
            tx_cnt_q    <= tx_cnt_d;
            ovf_q       <= ovf_d;
            rx_full_q   <= rx_full_d;
            rx_data_q   <= rx_data_d;
            rdata_q     <= rdata_d;
        end
    end

    // Storage arrays carry no reset
    always_ff @(posedge clk) begin
        if (ram_we)  ram_q[ram_idx]       <= bus.wdata;
        if (tx_push) tx_mem_q[tx_wr_ptr_q] <= bus.wdata;
    end

    assign bus.rdata       = rdata_q;
    assign bus.io_tx_data  = tx_mem_q[tx_rd_ptr_q];
    assign bus.io_tx_valid = tx_valid;
    assign bus.io_rx_ready = !rx_full_q;
endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: vector tables plus hand-written FIFO drain and async-reset sequences.
module tb_mem_responder;
    localparam int unsigned AW = 17;

    logic clk;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    mem_responder_if #(.ADDR_WIDTH(AW)) bus ();

    // RAM_AW=14 leaves addr[15:14] as alias bits
    mem_responder #(
        .ADDR_WIDTH(AW),
        .RAM_AW    (14),
        .TX_DEPTH  (8),
        .INIT_FILE ("ram.data")
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic          wr;
        logic [AW-1:0] addr;
        logic [7:0]    wdata;
        logic          txr;
        logic          rxv;
        logic [7:0]    rxd;
        logic [7:0]    exp_rdata;
        logic          exp_txv;
        logic          exp_rxr;
    } vec_t;

    function automatic vec_t mk(logic wr, logic [AW-1:0] addr, logic [7:0] wdata,
                                logic txr, logic rxv, logic [7:0] rxd,
                                logic [7:0] er, logic etv, logic err);
        vec_t v;
        v.wr = wr; v.addr = addr; v.wdata = wdata; v.txr = txr; v.rxv = rxv; v.rxd = rxd;
        v.exp_rdata = er; v.exp_txv = etv; v.exp_rxr = err;
        return v;
    endfunction

    task automatic check(string name, logic [7:0] act, logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%02h, want 0x%02h @%0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(logic wr, logic [AW-1:0] addr, logic [7:0] wdata,
                         logic txr, logic rxv, logic [7:0] rxd);
        bus.mem_ctrl_wr = wr;
        bus.addr        = addr;
        bus.wdata       = wdata;
        bus.io_tx_ready = txr;
        bus.io_rx_valid = rxv;
        bus.io_rx_data  = rxd;
    endtask

    // Inputs change at negedge; outputs are checked at the following negedge
    task automatic run_vec(vec_t v, string tag);
        drive(v.wr, v.addr, v.wdata, v.txr, v.rxv, v.rxd);
        @(negedge clk);
        check({tag, ".rdata"},    bus.rdata, v.exp_rdata);
        check({tag, ".tx_valid"}, 8'(bus.io_tx_valid), 8'(v.exp_txv));
        check({tag, ".rx_ready"}, 8'(bus.io_rx_ready), 8'(v.exp_rxr));
    endtask

    task automatic run_tab(vec_t tab[$], string tag);
        foreach (tab[i]) run_vec(tab[i], $sformatf("%s[%0d]", tag, i));
    endtask

    // Pop with ready=1 while reading RAM 0x10 (returns 0xA5) and check each head byte
    task automatic drain(logic [7:0] exp[$], string tag);
        foreach (exp[i]) begin
            check($sformatf("%s.head%0d", tag, i), bus.io_tx_data, exp[i]);
            check($sformatf("%s.valid%0d", tag, i), 8'(bus.io_tx_valid), 8'h01);
            drive(1'b0, 17'h00010, 8'h00, 1'b1, 1'b0, 8'h00);
            @(negedge clk);
        end
        check({tag, ".empty"}, 8'(bus.io_tx_valid), 8'h00);
        drive(1'b0, 17'h00010, 8'h00, 1'b0, 1'b0, 8'h00);
    endtask

    localparam logic [AW-1:0] TXD = 17'h10000;
    localparam logic [AW-1:0] STS = 17'h10004;

    initial begin
        vec_t tab_a[$];
        vec_t tab_b[$];
        vec_t tab_c[$];
        logic [7:0] exp_q[$];

        // RAM access, aliasing, then fill TX FIFO past full
        tab_a.push_back(mk(1, 17'h00010, 8'hA5, 0, 0, 8'h00, 8'h00, 0, 1));
        tab_a.push_back(mk(1, 17'h00011, 8'h3C, 0, 0, 8'h00, 8'h00, 0, 1));
        tab_a.push_back(mk(0, 17'h00010, 8'h00, 0, 0, 8'h00, 8'hA5, 0, 1));
        tab_a.push_back(mk(0, 17'h00011, 8'h00, 0, 0, 8'h00, 8'h3C, 0, 1));
        tab_a.push_back(mk(1, 17'h00005, 8'h77, 0, 0, 8'h00, 8'h3C, 0, 1));
        tab_a.push_back(mk(0, 17'h04005, 8'h00, 0, 0, 8'h00, 8'h77, 0, 1));
        for (int i = 1; i <= 8; i++)
            tab_a.push_back(mk(1, TXD, 8'(i), 0, 0, 8'h00, 8'h77, 1, 1));
        tab_a.push_back(mk(0, STS, 8'h00, 0, 0, 8'h00, 8'h01, 1, 1));
        tab_a.push_back(mk(1, TXD, 8'h09, 0, 0, 8'h00, 8'h01, 1, 1));
        tab_a.push_back(mk(0, STS, 8'h00, 0, 0, 8'h00, 8'h05, 1, 1));

        // Clear overflow, refill, push into full FIFO during a pop
        tab_b.push_back(mk(1, STS, 8'h00, 0, 0, 8'h00, 8'hA5, 0, 1));
        tab_b.push_back(mk(0, STS, 8'h00, 0, 0, 8'h00, 8'h00, 0, 1));
        for (int i = 0; i < 8; i++)
            tab_b.push_back(mk(1, TXD, 8'(8'h11 + i), 0, 0, 8'h00, 8'h00, 1, 1));
        tab_b.push_back(mk(1, TXD, 8'h55, 1, 0, 8'h00, 8'h00, 1, 1));
        tab_b.push_back(mk(0, STS, 8'h00, 0, 0, 8'h00, 8'h01, 1, 1));

        // RX capture, destructive read, empty reads, read-empty concurrent with capture
        tab_c.push_back(mk(0, 17'h00010, 8'h00, 0, 1, 8'h42, 8'hA5, 0, 0));
        tab_c.push_back(mk(0, STS, 8'h00, 0, 0, 8'h00, 8'h02, 0, 0));
        tab_c.push_back(mk(0, TXD, 8'h00, 0, 0, 8'h00, 8'h42, 0, 1));
        tab_c.push_back(mk(0, TXD, 8'h00, 0, 0, 8'h00, 8'h00, 0, 1));
        tab_c.push_back(mk(0, TXD, 8'h00, 0, 1, 8'h99, 8'h00, 0, 0));
        tab_c.push_back(mk(0, TXD, 8'h00, 0, 0, 8'h00, 8'h99, 0, 1));
        tab_c.push_back(mk(0, 17'h10002, 8'h00, 0, 0, 8'h00, 8'h00, 0, 1));
        tab_c.push_back(mk(0, 17'h00011, 8'h00, 0, 0, 8'h00, 8'h3C, 0, 1));
        for (int i = 0; i < 3; i++)
            tab_c.push_back(mk(1, TXD, 8'(8'hE0 + i), 0, 0, 8'h00, 8'h3C, 1, 1));

        rst = 1'b0;
        drive(1'b0, '0, 8'h00, 1'b0, 1'b0, 8'h00);
        repeat (3) @(negedge clk);
        check("reset.rdata", bus.rdata, 8'h00);
        check("reset.tx_valid", 8'(bus.io_tx_valid), 8'h00);
        check("reset.rx_ready", 8'(bus.io_rx_ready), 8'h01);
        rst = 1'b1;

        run_tab(tab_a, "A");
        exp_q = {};
        for (int i = 1; i <= 8; i++) exp_q.push_back(8'(i));
        drain(exp_q, "drain1");

        run_tab(tab_b, "B");
        exp_q = {};
        for (int i = 2; i <= 8; i++) exp_q.push_back(8'(8'h10 + i));
        exp_q.push_back(8'h55);
        drain(exp_q, "drain2");

        run_tab(tab_c, "C");

        // Asynchronous reset between edges with three bytes queued
        #2 rst = 1'b0;
        #1;
        check("areset.rdata", bus.rdata, 8'h00);
        check("areset.tx_valid", 8'(bus.io_tx_valid), 8'h00);
        check("areset.rx_ready", 8'(bus.io_rx_ready), 8'h01);
        @(negedge clk);
        rst = 1'b1;
        run_vec(mk(0, 17'h00010, 8'h00, 0, 0, 8'h00, 8'hA5, 0, 1), "post_rst.ram");
        run_vec(mk(0, STS, 8'h00, 0, 0, 8'h00, 8'h00, 0, 1), "post_rst.status");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
